// File: rtl/polling_sequencer_if.sv
// Link-controller enable, ordered-set transmit handshake and per-lane receive status of the polling sequencer.
interface polling_sequencer_if #(
   parameter int NUM_LANES = 1
);
   logic                 polling_en_i;
   logic [NUM_LANES-1:0] lane_mask_i;
   logic                 os_req_o;
   logic                 os_type_o;
   logic                 os_ack_i;
   logic [NUM_LANES-1:0] os_lane_en_o;
   logic [NUM_LANES-1:0] rx_os_valid_i;
   logic [NUM_LANES-1:0] rx_os_type_i;
   logic [NUM_LANES-1:0] rx_os_pad_i;
   logic [1:0]           state_o;
   logic                 done_o;
   logic                 fail_o;

   modport master (
      input  polling_en_i, lane_mask_i, os_ack_i, rx_os_valid_i, rx_os_type_i, rx_os_pad_i,
      output os_req_o, os_type_o, os_lane_en_o, state_o, done_o, fail_o
   );

   modport slave (
      output polling_en_i, lane_mask_i, os_ack_i, rx_os_valid_i, rx_os_type_i, rx_os_pad_i,
      input  os_req_o, os_type_o, os_lane_en_o, state_o, done_o, fail_o
   );
endinterface

// File: rtl/polling_sequencer.sv
// Polling.Active / Polling.Configuration sequencer: TS1/TS2 requests, per-lane consecutive-match tracking, timeout.
// Outputs are registered, one cycle after the deciding edge; os_req_o holds until os_ack_i, and a drop on abort/exit is tolerated.
module polling_sequencer #(
   parameter int NUM_LANES      = 1,
   parameter int TX_TS1_MIN     = 1024,
   parameter int RX_MATCH_MIN   = 8,
   parameter int TS2_TX_AFTER   = 16,
   parameter int TIMEOUT_CYCLES = 6000000
) (
   input logic               clk_i,
   input logic               rst_i,
   polling_sequencer_if.master bus
);
   localparam int TXW = $clog2(TX_TS1_MIN + 1);
   localparam int RXW = $clog2(RX_MATCH_MIN + 1);
   localparam int T2W = $clog2(TS2_TX_AFTER + 1);
   localparam int TMW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TXW-1:0] TX_MAX  = TXW'(TX_TS1_MIN);
   localparam logic [RXW-1:0] RX_MAX  = RXW'(RX_MATCH_MIN);
   localparam logic [T2W-1:0] T2_MAX  = T2W'(TS2_TX_AFTER);
   localparam logic [TMW-1:0] TM_LAST = TMW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_CONFIG = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [NUM_LANES-1:0] r_lane_en, w_lane_nxt;
   logic [TXW-1:0]       r_tx_cnt, w_tx_nxt;
   logic [T2W-1:0]       r_tx2_cnt, w_tx2_nxt;
   logic [RXW-1:0]       r_rx_cnt [NUM_LANES];
   logic [RXW-1:0]       w_rx_nxt [NUM_LANES];
   logic [TMW-1:0]       r_timer, w_timer_nxt;
   logic                 r_done, r_fail, w_done_nxt, w_fail_nxt;
   logic                 w_run, w_ack, w_all_sat, w_any_rx, w_clr;
   logic [NUM_LANES-1:0] w_match;

   // Exit decisions look only at registered counters; strobes affect them one edge later.
   always_comb begin
      w_run     = (r_state == S_ACTIVE) || (r_state == S_CONFIG);
      w_ack     = w_run && bus.os_ack_i;
      w_all_sat = 1'b1;
      w_any_rx  = 1'b0;
      w_match   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (r_lane_en[i]) begin
            if (r_rx_cnt[i] != RX_MAX) w_all_sat = 1'b0;
            if (r_rx_cnt[i] != '0)     w_any_rx  = 1'b1;
         end
         w_match[i] = bus.rx_os_valid_i[i] && bus.rx_os_pad_i[i] &&
                      ((r_state == S_ACTIVE) || bus.rx_os_type_i[i]);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_fail_nxt  = 1'b0;
      w_lane_nxt  = r_lane_en;
      case (r_state)
         S_IDLE: begin
            if (bus.polling_en_i) begin
               if (|bus.lane_mask_i) begin
                  w_state_nxt = S_ACTIVE;
                  w_lane_nxt  = bus.lane_mask_i;
               end else begin
                  w_state_nxt = S_HOLD;
                  w_fail_nxt  = 1'b1;
               end
            end
         end
         S_ACTIVE: begin
            if (!bus.polling_en_i) begin
               w_state_nxt = S_IDLE;
            end else if ((r_tx_cnt == TX_MAX) && w_all_sat && w_ack) begin
               w_state_nxt = S_CONFIG;
            end else if (r_timer == TM_LAST) begin
               w_state_nxt = S_HOLD;
               w_fail_nxt  = 1'b1;
            end
         end
         S_CONFIG: begin
            if (!bus.polling_en_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_all_sat && (r_tx2_cnt == T2_MAX)) begin
               w_state_nxt = S_HOLD;
               w_done_nxt  = 1'b1;
            end else if (r_timer == TM_LAST) begin
               w_state_nxt = S_HOLD;
               w_fail_nxt  = 1'b1;
            end
         end
         default: begin
            if (!bus.polling_en_i) w_state_nxt = S_IDLE;
         end
      endcase
      if (w_state_nxt == S_IDLE) w_lane_nxt = '0;
   end

   // Every state change restarts the timer and all set counters.
   always_comb begin
      w_clr       = (w_state_nxt != r_state);
      w_tx_nxt    = r_tx_cnt;
      w_tx2_nxt   = r_tx2_cnt;
      w_timer_nxt = r_timer;
      for (int i = 0; i < NUM_LANES; i++) w_rx_nxt[i] = r_rx_cnt[i];
      if (w_clr) begin
         w_tx_nxt    = '0;
         w_tx2_nxt   = '0;
         w_timer_nxt = '0;
         for (int i = 0; i < NUM_LANES; i++) w_rx_nxt[i] = '0;
      end else if (w_run) begin
         w_timer_nxt = r_timer + TMW'(1);
         if ((r_state == S_ACTIVE) && w_ack && (r_tx_cnt != TX_MAX))
            w_tx_nxt = r_tx_cnt + TXW'(1);
         if ((r_state == S_CONFIG) && w_ack && w_any_rx && (r_tx2_cnt != T2_MAX))
            w_tx2_nxt = r_tx2_cnt + T2W'(1);
         for (int i = 0; i < NUM_LANES; i++) begin
            if (r_lane_en[i] && bus.rx_os_valid_i[i]) begin
               if (!w_match[i])                w_rx_nxt[i] = '0;
               else if (r_rx_cnt[i] != RX_MAX) w_rx_nxt[i] = r_rx_cnt[i] + RXW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_lane_en <= '0;
         r_tx_cnt  <= '0;
         r_tx2_cnt <= '0;
         r_timer   <= '0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) r_rx_cnt[i] <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_lane_en <= w_lane_nxt;
         r_tx_cnt  <= w_tx_nxt;
         r_tx2_cnt <= w_tx2_nxt;
         r_timer   <= w_timer_nxt;
         r_done    <= w_done_nxt;
         r_fail    <= w_fail_nxt;
         for (int i = 0; i < NUM_LANES; i++) r_rx_cnt[i] <= w_rx_nxt[i];
      end
   end

   assign bus.state_o      = r_state;
   assign bus.os_req_o     = (r_state == S_ACTIVE) || (r_state == S_CONFIG);
   assign bus.os_type_o    = (r_state == S_CONFIG);
   assign bus.os_lane_en_o = r_lane_en;
   assign bus.done_o       = r_done;
   assign bus.fail_o       = r_fail;
endmodule

// File: tb/tb_polling_sequencer.sv
// Directed scenarios plus a randomized run, each cycle checked against a behavioural model of the polling rules.
module tb_polling_sequencer;
   localparam int NL  = 4;
   localparam int TXN = 16;
   localparam int RXN = 8;
   localparam int T2N = 4;
   localparam int TO  = 200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   polling_sequencer_if #(.NUM_LANES(NL)) bus ();

   polling_sequencer #(
      .NUM_LANES(NL), .TX_TS1_MIN(TXN), .RX_MATCH_MIN(RXN),
      .TS2_TX_AFTER(T2N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int n_failp  = 0;

   // Reference: substate number, latched mask, set counts, per-lane run lengths, cycles in substate.
   int       m_state;
   logic [3:0] m_lane;
   int       m_tx, m_tx2, m_timer;
   int       m_rx [NL];
   bit       m_done, m_fail;

   function automatic int sat_inc(int v, int lim);
      return (v + 1 > lim) ? lim : v + 1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_lane = '0; m_tx = 0; m_tx2 = 0; m_timer = 0;
      m_done = 0; m_fail = 0;
      for (int i = 0; i < NL; i++) m_rx[i] = 0;
   endtask

   task automatic model_step();
      int nxt;
      bit sending, acc, allsat, anyrx, tmo, en;
      en      = bus.polling_en_i;
      sending = (m_state == 1) || (m_state == 2);
      acc     = sending && bus.os_ack_i;
      allsat  = 1; anyrx = 0;
      for (int i = 0; i < NL; i++)
         if (m_lane[i]) begin
            if (m_rx[i] != RXN) allsat = 0;
            if (m_rx[i] >= 1)   anyrx  = 1;
         end
      tmo = (m_timer == TO - 1);
      nxt = m_state; m_done = 0; m_fail = 0;
      if (m_state == 0) begin
         if (en && bus.lane_mask_i != 0) begin nxt = 1; m_lane = bus.lane_mask_i; end
         else if (en) begin nxt = 3; m_fail = 1; end
      end else if (m_state == 1) begin
         if (!en) nxt = 0;
         else if (m_tx == TXN && allsat && acc) nxt = 2;
         else if (tmo) begin nxt = 3; m_fail = 1; end
      end else if (m_state == 2) begin
         if (!en) nxt = 0;
         else if (allsat && m_tx2 == T2N) begin nxt = 3; m_done = 1; end
         else if (tmo) begin nxt = 3; m_fail = 1; end
      end else if (!en) nxt = 0;
      if (nxt != m_state) begin
         m_tx = 0; m_tx2 = 0; m_timer = 0;
         for (int i = 0; i < NL; i++) m_rx[i] = 0;
         if (nxt == 0) m_lane = '0;
      end else if (sending) begin
         m_timer++;
         if (acc && m_state == 1) m_tx = sat_inc(m_tx, TXN);
         if (acc && m_state == 2 && anyrx) m_tx2 = sat_inc(m_tx2, T2N);
         for (int i = 0; i < NL; i++)
            if (m_lane[i] && bus.rx_os_valid_i[i]) begin
               if (bus.rx_os_pad_i[i] && (m_state == 1 || bus.rx_os_type_i[i])) m_rx[i] = sat_inc(m_rx[i], RXN);
               else m_rx[i] = 0;
            end
      end
      m_state = nxt;
   endtask

   function automatic logic [9:0] exp_vec();
      return {2'(m_state), (m_state == 1) || (m_state == 2), (m_state == 2), m_lane, m_done, m_fail};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {bus.state_o, bus.os_req_o, bus.os_type_o, bus.os_lane_en_o, bus.done_o, bus.fail_o};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      model_step();
      #1;
      if (bus.done_o) n_done++;
      if (bus.fail_o) n_failp++;
      check(tag, 32'(dut_vec()), 32'(exp_vec()));
   endtask

   task automatic strobe(logic [3:0] v, logic [3:0] t, logic [3:0] p, string tag);
      bus.rx_os_valid_i = v; bus.rx_os_type_i = t; bus.rx_os_pad_i = p;
      tick(tag);
      bus.rx_os_valid_i = '0;
   endtask

   initial begin
      int cyc, d0, f0;
      logic [3:0] r;
      rst = 1'b1;
      bus.polling_en_i = 0; bus.lane_mask_i = '0; bus.os_ack_i = 0;
      bus.rx_os_valid_i = '0; bus.rx_os_type_i = '0; bus.rx_os_pad_i = '0;
      model_reset();
      #12;
      check("reset_vec", 32'(dut_vec()), 32'd0);
      @(negedge clk); rst = 1'b0;
      tick("idle");

      // Nominal: lanes 0 and 2, TS1 then TS2, mask change after entry ignored
      bus.lane_mask_i = 4'b0101; bus.os_ack_i = 1; bus.polling_en_i = 1;
      tick("s1_entry");
      check("s1_active", 32'(bus.state_o), 32'd1);
      bus.lane_mask_i = 4'b1010;
      cyc = 0;
      for (int k = 0; k < RXN; k++) begin
         r = 4'($urandom);
         strobe(4'b0101 | (r & 4'b1010), 4'($urandom), 4'b0101 | (4'($urandom) & 4'b1010), "s1_ts1_rx");
         cyc++;
      end
      for (int k = 0; k < 40 && bus.state_o != 2'd2; k++) begin tick("s1_wait_cfg"); cyc++; end
      check("s1_cfg_state", 32'(bus.state_o), 32'd2);
      check("s1_ts1_cycles", 32'(cyc), 32'(TXN + 1));
      d0 = n_done;
      for (int k = 0; k < RXN; k++)
         strobe(4'b0101 | (4'($urandom) & 4'b1010), 4'b0101 | 4'($urandom), 4'b0101, "s1_ts2_rx");
      for (int k = 0; k < 20 && bus.state_o != 2'd3; k++) tick("s1_wait_done");
      check("s1_done_hold", 32'({bus.state_o, bus.done_o}), 32'({2'd3, 1'b1}));
      tick("s1_hold"); tick("s1_hold");
      check("s1_done_once", 32'(n_done - d0), 32'd1);
      check("s1_lane_en", 32'(bus.os_lane_en_o), 32'h5);
      bus.polling_en_i = 0; tick("s1_exit");
      check("s1_idle", 32'(bus.state_o), 32'd0);

      // A non-matching set restarts the consecutive count on lane 2
      bus.lane_mask_i = 4'b0100; bus.polling_en_i = 1;
      tick("s2_entry");
      repeat (20) tick("s2_fill_tx");
      for (int k = 0; k < 7; k++) strobe(4'b0100, 4'($urandom), 4'b0100, "s2_rx");
      strobe(4'b0100, 4'($urandom), 4'b0000, "s2_nopad");
      for (int k = 0; k < 8; k++) begin
         strobe(4'b0100, 4'($urandom), 4'b0100, "s2_rx2");
         check("s2_still_active", 32'(bus.state_o), 32'd1);
      end
      tick("s2_trans");
      check("s2_cfg", 32'(bus.state_o), 32'd2);
      bus.polling_en_i = 0; tick("s2_exit");

      // Ack gating on the TS1 -> TS2 boundary
      bus.lane_mask_i = 4'b1111; bus.polling_en_i = 1;
      tick("s3_entry");
      repeat (TXN) tick("s3_fill_tx");
      bus.os_ack_i = 0;
      for (int k = 0; k < RXN; k++) strobe(4'b1111, 4'($urandom), 4'b1111, "s3_rx");
      for (int k = 0; k < 10; k++) begin
         tick("s3_noack");
         check("s3_hold_ts1", 32'({bus.state_o, bus.os_type_o}), 32'({2'd1, 1'b0}));
      end
      bus.os_ack_i = 1;
      tick("s3_ack");
      check("s3_to_cfg", 32'({bus.state_o, bus.os_type_o}), 32'({2'd2, 1'b1}));

      // Abort from CONFIG, then restart from a fresh TS1 count
      d0 = n_done; f0 = n_failp;
      bus.polling_en_i = 0; tick("s5_abort");
      check("s5_idle", 32'({bus.state_o, bus.os_req_o}), 32'({2'd0, 1'b0}));
      check("s5_no_pulse", 32'((n_done - d0) + (n_failp - f0)), 32'd0);
      bus.polling_en_i = 1; tick("s5_reentry");
      cyc = 0;
      for (int k = 0; k < RXN; k++) begin strobe(4'b1111, 4'($urandom), 4'b1111, "s5_rx"); cyc++; end
      for (int k = 0; k < 40 && bus.state_o != 2'd2; k++) begin tick("s5_wait_cfg"); cyc++; end
      check("s5_restart_cycles", 32'(cyc), 32'(TXN + 1));
      bus.polling_en_i = 0; tick("s5_exit");

      // Timeout with no receive activity
      bus.lane_mask_i = 4'b0001; bus.polling_en_i = 1;
      tick("s4_entry");
      cyc = 0;
      for (int k = 0; k < 300 && !bus.fail_o; k++) begin
         bus.os_ack_i = 1'($urandom);
         tick("s4_wait");
         cyc++;
      end
      check("s4_timeout_cycles", 32'(cyc), 32'(TO));
      check("s4_hold", 32'(bus.state_o), 32'd3);
      bus.polling_en_i = 0; tick("s4_exit");
      check("s4_idle", 32'(bus.state_o), 32'd0);

      // Zero mask
      bus.os_ack_i = 1; bus.lane_mask_i = 4'b0000; bus.polling_en_i = 1;
      tick("s6_zero");
      check("s6_zero_fail", 32'({bus.state_o, bus.fail_o}), 32'({2'd3, 1'b1}));
      tick("s6_zero_hold");
      check("s6_fail_once", 32'({bus.state_o, bus.fail_o}), 32'({2'd3, 1'b0}));
      bus.polling_en_i = 0; tick("s6_exit");

      // Asynchronous reset while in CONFIG
      bus.lane_mask_i = 4'b0001; bus.polling_en_i = 1;
      tick("s6_entry");
      for (int k = 0; k < RXN; k++) strobe(4'b0001, 4'($urandom), 4'b0001, "s6_rx");
      for (int k = 0; k < 40 && bus.state_o != 2'd2; k++) tick("s6_wait_cfg");
      check("s6_in_cfg", 32'(bus.state_o), 32'd2);
      @(negedge clk); rst = 1'b1; #1;
      model_reset();
      check("s6_async_rst", 32'(dut_vec()), 32'd0);
      @(negedge clk); rst = 1'b0; bus.polling_en_i = 0;
      tick("s6_after_rst");

      // Randomized run
      for (int k = 0; k < 3000; k++) begin
         bus.polling_en_i  = ($urandom_range(0, 63) != 0);
         bus.lane_mask_i   = ($urandom_range(0, 15) == 0) ? 4'b0000 : 4'($urandom);
         bus.os_ack_i      = ($urandom_range(0, 3) != 0);
         bus.rx_os_valid_i = 4'($urandom);
         bus.rx_os_type_i  = ($urandom_range(0, 1) != 0) ? 4'b1111 : 4'($urandom);
         bus.rx_os_pad_i   = ($urandom_range(0, 7) != 0) ? 4'b1111 : 4'($urandom);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
